bram_frame_streamer: RTL and testbench

BRAM_FRAME_STREAMER -- requirements
Module: bram_frame_streamer

---
 rtl/bram_frame_streamer.sv | 124 ++++++++++++
 tb/tb_bram_frame_streamer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/bram_frame_streamer.sv
// Reads a frame from N side-by-side BRAMs and streams it as NB_PARALLEL_PIXELS pixels per beat.
// Optional macro BRAM_FRAME_STREAMER_LAST_EN adds an m_last output on the final beat.
module bram_frame_streamer #(
  parameter int unsigned ADDR_WIDTH         = 14,
  parameter int unsigned DATA_WIDTH_BRAM    = 72,
  parameter int unsigned N                  = 3,
  parameter int unsigned NUM_BYTES          = 259200,
  parameter int unsigned NB_PARALLEL_PIXELS = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  output logic                               bram_en,
  output logic [ADDR_WIDTH-1:0]              bram_addr,
  input  logic [DATA_WIDTH_BRAM*N-1:0]       bram_data_in,
  output logic [8*NB_PARALLEL_PIXELS-1:0]    m_data,
  output logic                               m_valid,
  input  logic                               m_ready,
  output logic                               busy,
  output logic                               done
`ifdef BRAM_FRAME_STREAMER_LAST_EN
  ,
  output logic                               m_last
`endif
);

  localparam int unsigned W          = DATA_WIDTH_BRAM * N;
  localparam int unsigned B          = W / 8;
  localparam int unsigned P          = NB_PARALLEL_PIXELS;
  localparam int unsigned NWORDS     = (NUM_BYTES + B - 1) / B;
  localparam int unsigned LAST_BYTES = NUM_BYTES - B * (NWORDS - 1);
  localparam int unsigned BUF_BYTES  = B + P - 1;
  localparam int unsigned BUF_BITS   = 8 * BUF_BYTES;
  localparam int unsigned CW         = $clog2(BUF_BYTES + 1);
  localparam int unsigned WCW        = ADDR_WIDTH + 1;

  typedef enum logic [2:0] {StIdle, StFetch, StWait, StStream, StDone} state_e;

  state_e              state_q, state_d;
  logic [WCW-1:0]      word_q, word_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [BUF_BITS-1:0] buf_q, buf_d;

  logic                all_fetched;
  logic                last_word;
  logic [CW-1:0]       word_bytes;
  logic [CW-1:0]       take;
  logic [W-1:0]        masked;
  logic                xfer;

  assign all_fetched = (word_q == WCW'(NWORDS));
  assign last_word   = (word_q == WCW'(NWORDS - 1));
  assign word_bytes  = last_word ? CW'(LAST_BYTES) : CW'(B);
  assign take        = (cnt_q >= CW'(P)) ? CW'(P) : cnt_q;

  // Bytes past the frame end are zeroed so the buffer stays clean above count.
  always_comb begin
    masked = '0;
    for (int k = 0; k < int'(B); k++) begin
      if (CW'(k) < word_bytes) masked[8*k +: 8] = bram_data_in[8*k +: 8];
    end
  end

  assign m_valid   = (state_q == StStream) &&
                     ((cnt_q >= CW'(P)) || ((cnt_q != '0) && all_fetched));
  assign xfer      = m_valid && m_ready;
  assign m_data    = m_valid ? buf_q[8*P-1:0] : '0;
  assign bram_en   = (state_q == StFetch);
  assign bram_addr = (state_q == StFetch) ? word_q[ADDR_WIDTH-1:0] : '0;
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);
`ifdef BRAM_FRAME_STREAMER_LAST_EN
  assign m_last    = m_valid && all_fetched && (cnt_q <= CW'(P));
`endif

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StFetch;
          word_d  = '0;
          cnt_d   = '0;
          buf_d   = '0;
        end
      end
      StFetch: state_d = StWait;
      StWait: begin
        buf_d   = buf_q | (BUF_BITS'(masked) << {cnt_q, 3'b000});
        cnt_d   = cnt_q + word_bytes;
        word_d  = word_q + WCW'(1);
        state_d = StStream;
      end
      StStream: begin
        if (xfer) begin
          buf_d = buf_q >> (8 * P);
          cnt_d = cnt_q - take;
        end
        if ((cnt_d < CW'(P)) && !all_fetched) state_d = StFetch;
        else if ((cnt_d == '0) && all_fetched) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      word_q  <= '0;
      cnt_q   <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
    end
  end

endmodule

// File: tb/tb_bram_frame_streamer.sv
// Directed bench for bram_frame_streamer on a 57-byte frame (3 words, last word 3 bytes).
module tb_bram_frame_streamer;

  localparam int unsigned NB     = 57;
  localparam int unsigned NWORDS = 3;
  localparam int unsigned NBEATS = 29;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         bram_en;
  logic [13:0]  bram_addr;
  logic [215:0] bram_q = '0;
  logic [15:0]  m_data;
  logic         m_valid;
  logic         m_ready = 1'b1;
  logic         busy;
  logic         done;
`ifdef BRAM_FRAME_STREAMER_LAST_EN
  logic         m_last;
`endif

  int n_checks = 0;
  int n_bad = 0;
  int beat_cnt = 0;
  int done_cnt = 0;
  int fetch_cnt = 0;
  int valid_cnt = 0;
  logic        stalled = 1'b0;
  logic [15:0] held = '0;

  bram_frame_streamer #(
    .NUM_BYTES(NB)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .bram_en      (bram_en),
    .bram_addr    (bram_addr),
    .bram_data_in (bram_q),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .busy         (busy),
    .done         (done)
`ifdef BRAM_FRAME_STREAMER_LAST_EN
    ,
    .m_last       (m_last)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [215:0] bram_word(input int a);
    logic [215:0] w;
    for (int k = 0; k < 27; k++) w[8*k +: 8] = 8'((27 * a + k) % 256);
    return w;
  endfunction

  function automatic logic [15:0] exp_beat(input int j);
    logic [15:0] v;
    for (int i = 0; i < 2; i++) begin
      int n;
      n = 2 * j + i;
      v[8*i +: 8] = (n < int'(NB)) ? 8'(n % 256) : 8'h00;
    end
    return v;
  endfunction

  always @(posedge clk) if (bram_en) bram_q <= bram_word(int'(bram_addr));

  // Monitor: beat data, backpressure stability, fetch order, done placement.
  always @(negedge clk) begin
    if (rst) begin
      stalled = 1'b0;
    end else begin
      if (start && !busy) begin
        beat_cnt = 0;
        done_cnt = 0;
        fetch_cnt = 0;
      end
      if (stalled) begin
        check_eq("stall_valid", 64'(m_valid), 64'd1);
        check_eq("stall_data", 64'(m_data), 64'(held));
      end
      if (m_valid) valid_cnt++;
      if (m_valid && m_ready) begin
        check_eq($sformatf("beat%0d", beat_cnt), 64'(m_data), 64'(exp_beat(beat_cnt)));
`ifdef BRAM_FRAME_STREAMER_LAST_EN
        check_eq("m_last", 64'(m_last), 64'(beat_cnt == int'(NBEATS) - 1));
`endif
        beat_cnt++;
      end
      stalled = m_valid && !m_ready;
      held = m_data;
      if (bram_en) begin
        check_eq("fetch_addr", 64'(bram_addr), 64'(fetch_cnt));
        fetch_cnt++;
      end
      if (done) begin
        check_eq("done_after_beats", 64'(beat_cnt), 64'(NBEATS));
        done_cnt++;
      end
    end
  end

  task automatic start_frame();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check_eq("lat_en_c1", 64'(bram_en), 64'd1);
    check_eq("lat_addr_c1", 64'(bram_addr), 64'd0);
    check_eq("lat_busy_c1", 64'(busy), 64'd1);
    @(posedge clk); #1;
    check_eq("lat_en_c2", 64'(bram_en), 64'd0);
    @(posedge clk); #1;
    check_eq("lat_valid_c3", 64'(m_valid), 64'd1);
  endtask

  task automatic finish_frame(input bit toggle, input bit restart_mid);
    logic [3:0] pat;
    int i;
    pat = 4'b1001;
    for (i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (toggle) m_ready = pat[i % 4];
      if (restart_mid) start = (i == 8);
      if (done_cnt > 0) break;
    end
    start = 1'b0;
    m_ready = 1'b1;
    check_eq("done_seen", 64'(done_cnt > 0), 64'd1);
    repeat (30) @(posedge clk);
    #1;
    check_eq("done_count", 64'(done_cnt), 64'd1);
    check_eq("beat_count", 64'(beat_cnt), 64'(NBEATS));
    check_eq("fetch_count", 64'(fetch_cnt), 64'(NWORDS));
    check_eq("idle_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    int v0;
    #1;
    check_eq("rst_en", 64'(bram_en), 64'd0);
    check_eq("rst_addr", 64'(bram_addr), 64'd0);
    check_eq("rst_valid", 64'(m_valid), 64'd0);
    check_eq("rst_data", 64'(m_data), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);

    // Frame with continuous ready.
    start_frame();
    finish_frame(1'b0, 1'b0);

    // Ready pattern 1,0,0,1 plus a stray start mid-stream.
    start_frame();
    finish_frame(1'b1, 1'b1);

    // Reset mid-frame, then restart.
    start_frame();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (beat_cnt >= 10) break;
    end
    check_eq("reached_beat10", 64'(beat_cnt >= 10), 64'd1);
    #2 rst = 1'b1;
    #1;
    check_eq("arst_valid", 64'(m_valid), 64'd0);
    check_eq("arst_data", 64'(m_data), 64'd0);
    check_eq("arst_en", 64'(bram_en), 64'd0);
    check_eq("arst_addr", 64'(bram_addr), 64'd0);
    check_eq("arst_busy", 64'(busy), 64'd0);
    check_eq("arst_done", 64'(done), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    v0 = valid_cnt;
    repeat (20) @(posedge clk);
    #1;
    check_eq("no_valid_after_rst", 64'(valid_cnt), 64'(v0));
    start_frame();
    finish_frame(1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
